up_down_counter_param: RTL and testbench

Parametrised up/down counter, the successor to the fixed 4-bit up/down counter. It has configurable width and modulus, a run-time step size, wrap or saturate mode, and a clamped parallel load. It also provides terminal-count, wrap-pulse and sticky overflow/underflow status. It is used as a general counting/timebase primitive in the lab designs, for example as a decade counter for display drivers or a modulo-N prescaler.

---
 rtl/up_down_counter_param_if.sv | 45 ++++
 rtl/up_down_counter_param.sv | 107 ++++++++++
 tb/tb_up_down_counter_param.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_param_if.sv
// Purpose : bundles the control inputs and status outputs of up_down_counter_param.
// Latency : none (wires only).
// Backpressure: none; the counter accepts a command on every clock edge.
//
// Port summary (seen from the counter, i.e. the slave modport):
//   in  Enable          apply one step this edge
//   in  UpDown          1 = count up, 0 = count down
//   in  Step            step size (values above MAX_COUNT act as MAX_COUNT)
//   in  Saturate        0 = wrap modulo MAX_COUNT+1, 1 = clip at 0 / MAX_COUNT
//   in  LoadCount       synchronous parallel load, highest priority
//   in  CounterLoad     load value (clamped to MAX_COUNT)
//   in  ClearFlags      synchronous clear of both sticky flags
//   out CounterOutput   registered count
//   out TerminalCount   combinational end-of-range indication for the current direction
//   out Wrap            one-cycle pulse after an enabled crossing edge
//   out OverflowSticky  set by an up-crossing, held until cleared
//   out UnderflowSticky set by a down-crossing, held until cleared
interface up_down_counter_param_if #(
  parameter int WIDTH = 4
);
  logic             Enable;
  logic             UpDown;
  logic [WIDTH-1:0] Step;
  logic             Saturate;
  logic             LoadCount;
  logic [WIDTH-1:0] CounterLoad;
  logic             ClearFlags;
  logic [WIDTH-1:0] CounterOutput;
  logic             TerminalCount;
  logic             Wrap;
  logic             OverflowSticky;
  logic             UnderflowSticky;

  // Whoever drives the counter.
  modport master (
    output Enable, UpDown, Step, Saturate, LoadCount, CounterLoad, ClearFlags,
    input  CounterOutput, TerminalCount, Wrap, OverflowSticky, UnderflowSticky
  );

  // The counter itself.
  modport slave (
    input  Enable, UpDown, Step, Saturate, LoadCount, CounterLoad, ClearFlags,
    output CounterOutput, TerminalCount, Wrap, OverflowSticky, UnderflowSticky
  );
endinterface

// File: rtl/up_down_counter_param.sv
// Purpose : parametrised up/down counter with run-time step, wrap/saturate mode, clamped load and status flags.
// Latency : load/count visible on CounterOutput one edge after sampling; Wrap and sticky flags update on the same edge; TerminalCount is combinational.
// Backpressure: none; a new command is accepted on every clock edge.
//
// Ports:
//   Clock    rising-edge clock
//   Reset_n  asynchronous active-low reset; forces count to RESET_VALUE and clears Wrap and both flags
//   bus      up_down_counter_param_if.slave (see interface file for the per-signal summary)
// Parameters:
//   WIDTH        counter width (>= 2)
//   MAX_COUNT    highest legal count, 1 .. 2**WIDTH-1
//   RESET_VALUE  count after reset, <= MAX_COUNT
module up_down_counter_param #(
  parameter int WIDTH       = 4,
  parameter int MAX_COUNT   = (1 << WIDTH) - 1,
  parameter int RESET_VALUE = 0
) (
  input logic                     Clock,
  input logic                     Reset_n,
  up_down_counter_param_if.slave  bus
);

  // Constants at counter width and at one extra bit. The extra bit keeps
  // count+step and count+modulus exact: both are at most 2*MAX_COUNT+1,
  // which always fits in WIDTH+1 bits.
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RESET_W    = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   MAX_EXT    = (WIDTH + 1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   MODULUS    = (WIDTH + 1)'(MAX_COUNT + 1);

  logic [WIDTH-1:0] countQ;
  logic             wrapQ;
  logic             overflowQ;
  logic             underflowQ;

  logic [WIDTH-1:0] stepEff;
  logic [WIDTH-1:0] loadEff;
  logic [WIDTH:0]   countExt;
  logic [WIDTH:0]   stepExt;
  logic [WIDTH:0]   sumExt;
  logic [WIDTH-1:0] countNext;
  logic             crossUp;
  logic             crossDown;

  // Out-of-range step and load values are pulled back to MAX_COUNT so the
  // arithmetic below never has to reason about operands beyond the range.
  always_comb begin
    stepEff = (bus.Step > MAX_W) ? MAX_W : bus.Step;
    loadEff = (bus.CounterLoad > MAX_W) ? MAX_W : bus.CounterLoad;
  end

  always_comb begin
    countExt  = {1'b0, countQ};
    stepExt   = {1'b0, stepEff};
    sumExt    = countExt + stepExt;
    countNext = countQ;
    crossUp   = 1'b0;
    crossDown = 1'b0;

    if (bus.LoadCount) begin
      // Load beats counting and never raises a crossing.
      countNext = loadEff;
    end else if (bus.Enable && (stepEff != '0)) begin
      if (bus.UpDown) begin
        if (sumExt <= MAX_EXT) begin
          countNext = sumExt[WIDTH-1:0];
        end else begin
          // Saturating at the bound still counts as a crossing, even when
          // the count was already sitting there.
          crossUp   = 1'b1;
          countNext = bus.Saturate ? MAX_W : WIDTH'(sumExt - MODULUS);
        end
      end else begin
        if (stepExt <= countExt) begin
          countNext = WIDTH'(countExt - stepExt);
        end else begin
          crossDown = 1'b1;
          countNext = bus.Saturate ? '0 : WIDTH'(countExt + MODULUS - stepExt);
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      countQ     <= RESET_W;
      wrapQ      <= 1'b0;
      overflowQ  <= 1'b0;
      underflowQ <= 1'b0;
    end else begin
      countQ     <= countNext;
      wrapQ      <= crossUp | crossDown;
      // A crossing on the same edge as a clear keeps the flag set.
      overflowQ  <= crossUp   | (overflowQ  & ~bus.ClearFlags);
      underflowQ <= crossDown | (underflowQ & ~bus.ClearFlags);
    end
  end

  assign bus.CounterOutput   = countQ;
  assign bus.Wrap            = wrapQ;
  assign bus.OverflowSticky  = overflowQ;
  assign bus.UnderflowSticky = underflowQ;
  // End of range depends on the direction currently requested, not the
  // direction of the last step.
  assign bus.TerminalCount   = bus.UpDown ? (countQ == MAX_W) : (countQ == '0);

endmodule

// File: tb/tb_up_down_counter_param.sv
// Purpose : directed self-checking bench for up_down_counter_param (WIDTH=4, MAX_COUNT=9, RESET_VALUE=0).
// Latency : outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_up_down_counter_param;
  logic Clock;
  logic Reset_n;
  int   assertCount;
  int   failCount;

  up_down_counter_param_if #(.WIDTH(4)) bus ();

  up_down_counter_param #(
    .WIDTH(4),
    .MAX_COUNT(9),
    .RESET_VALUE(0)
  ) dut (
    .Clock(Clock),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkState(input string name, input int expCount, input bit expWrap,
                            input bit expOvf, input bit expUnf);
    // Each field compared separately so a failure names the signal.
    assertCount++;
    if (bus.CounterOutput !== 4'(expCount)) begin
      failCount++;
      $display("FAIL %s count: got %0d expected %0d", name, bus.CounterOutput, expCount);
    end
    assertCount++;
    if (bus.Wrap !== expWrap) begin
      failCount++;
      $display("FAIL %s wrap: got %b expected %b", name, bus.Wrap, expWrap);
    end
    assertCount++;
    if (bus.OverflowSticky !== expOvf) begin
      failCount++;
      $display("FAIL %s ovf: got %b expected %b", name, bus.OverflowSticky, expOvf);
    end
    assertCount++;
    if (bus.UnderflowSticky !== expUnf) begin
      failCount++;
      $display("FAIL %s unf: got %b expected %b", name, bus.UnderflowSticky, expUnf);
    end
  endtask

  task automatic test_reset();
    Reset_n         = 1'b0;
    bus.Enable      = 1'b0;
    bus.UpDown      = 1'b1;
    bus.Step        = 4'd1;
    bus.Saturate    = 1'b0;
    bus.LoadCount   = 1'b0;
    bus.CounterLoad = 4'd0;
    bus.ClearFlags  = 1'b0;
    #2;
    checkState("reset", 0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
    checkState("reset_release_idle", 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_up_wrap();
    bus.Enable = 1'b1;
    bus.UpDown = 1'b1;
    bus.Step   = 4'd1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checkState("up_count", i, 1'b0, 1'b0, 1'b0);
      assertCount++;
      if (bus.TerminalCount !== (i == 9)) begin
        failCount++;
        $display("FAIL up_tc at %0d: got %b expected %b", i, bus.TerminalCount, (i == 9));
      end
    end
    tick();
    checkState("up_wrap_edge", 0, 1'b1, 1'b1, 1'b0);
    tick();
    checkState("up_after_wrap", 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_down_step3();
    // Load 1 and clear flags on a non-crossing edge.
    bus.Enable      = 1'b0;
    bus.LoadCount   = 1'b1;
    bus.CounterLoad = 4'd1;
    bus.ClearFlags  = 1'b1;
    tick();
    checkState("down_preload", 1, 1'b0, 1'b0, 1'b0);
    bus.LoadCount  = 1'b0;
    bus.ClearFlags = 1'b0;
    bus.Enable     = 1'b1;
    bus.UpDown     = 1'b0;
    bus.Step       = 4'd3;
    bus.Saturate   = 1'b0;
    tick();
    checkState("down_wrap", 8, 1'b1, 1'b0, 1'b1);
    assertCount++;
    if (bus.TerminalCount !== 1'b0) begin
      failCount++;
      $display("FAIL down_tc_at8: got %b expected 0", bus.TerminalCount);
    end
    bus.Enable     = 1'b0;
    bus.LoadCount  = 1'b1;
    bus.ClearFlags = 1'b1;
    tick();
    checkState("down_reload", 1, 1'b0, 1'b0, 1'b0);
    bus.LoadCount  = 1'b0;
    bus.ClearFlags = 1'b0;
    bus.Enable     = 1'b1;
    bus.Saturate   = 1'b1;
    tick();
    checkState("down_sat", 0, 1'b1, 1'b0, 1'b1);
    assertCount++;
    if (bus.TerminalCount !== 1'b1) begin
      failCount++;
      $display("FAIL down_tc_at0: got %b expected 1", bus.TerminalCount);
    end
    tick();
    checkState("down_sat_again", 0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_load_clamp();
    bus.Saturate    = 1'b0;
    bus.Enable      = 1'b1;
    bus.UpDown      = 1'b1;
    bus.Step        = 4'd1;
    bus.LoadCount   = 1'b1;
    bus.CounterLoad = 4'b1010;
    tick();
    checkState("load_clamp", 9, 1'b0, 1'b0, 1'b1);
    bus.CounterLoad = 4'd4;
    tick();
    checkState("load_4", 4, 1'b0, 1'b0, 1'b1);
    bus.LoadCount = 1'b0;
  endtask

  task automatic test_flag_clear_race();
    bus.Enable      = 1'b0;
    bus.LoadCount   = 1'b1;
    bus.CounterLoad = 4'd9;
    bus.ClearFlags  = 1'b1;
    tick();
    checkState("race_setup", 9, 1'b0, 1'b0, 1'b0);
    bus.LoadCount = 1'b0;
    bus.Enable    = 1'b1;
    bus.UpDown    = 1'b1;
    bus.Step      = 4'd1;
    tick();
    checkState("race_set_wins", 0, 1'b1, 1'b1, 1'b0);
    bus.Enable = 1'b0;
    tick();
    checkState("race_clear", 0, 1'b0, 1'b0, 1'b0);
    bus.ClearFlags = 1'b0;
  endtask

  task automatic test_hold_and_step();
    bus.Enable = 1'b0;
    bus.UpDown = 1'b0;
    bus.Step   = 4'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkState("hold_disabled", 0, 1'b0, 1'b0, 1'b0);
    end
    bus.Enable = 1'b1;
    bus.Step   = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkState("hold_step0", 0, 1'b0, 1'b0, 1'b0);
    end
    bus.LoadCount   = 1'b1;
    bus.CounterLoad = 4'd2;
    tick();
    checkState("step15_preload", 2, 1'b0, 1'b0, 1'b0);
    bus.LoadCount = 1'b0;
    bus.UpDown    = 1'b1;
    bus.Step      = 4'd15;
    bus.Saturate  = 1'b0;
    tick();
    checkState("step15_wrap", 1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    // Count is 1, overflow set; take a down crossing to set underflow too.
    bus.Enable = 1'b1;
    bus.UpDown = 1'b0;
    bus.Step   = 4'd3;
    tick();
    checkState("ar_setup_down", 8, 1'b1, 1'b1, 1'b1);
    bus.Enable      = 1'b0;
    bus.LoadCount   = 1'b1;
    bus.CounterLoad = 4'd7;
    tick();
    checkState("ar_setup_load", 7, 1'b0, 1'b1, 1'b1);
    // Drop reset mid-cycle with a load and count both requested.
    bus.Enable      = 1'b1;
    bus.UpDown      = 1'b1;
    bus.Step        = 4'd1;
    bus.CounterLoad = 4'd5;
    #3;
    Reset_n = 1'b0;
    #1;
    checkState("ar_immediate", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkState("ar_held", 0, 1'b0, 1'b0, 1'b0);
    end
    Reset_n       = 1'b1;
    bus.LoadCount = 1'b0;
    tick();
    checkState("ar_first_count", 1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    test_reset();
    test_up_wrap();
    test_down_step3();
    test_load_clamp();
    test_flag_clear_race();
    test_hold_and_step();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
